// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction-fetch stage.
// Owns the PC, fetches one instruction at a time over a req/ack handshake
// and holds Instr/PC stable until execute retires the instruction.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (halt on a target with bit[1] set).
//
// state | meaning
// IDLE  | reset state, leaves on the first clock after reset release
// FETCH | request outstanding, imem_addr = PC held stable
// HOLD  | instruction presented to decode, waits for instr_ready
// HALT  | misaligned target seen (trap build only), exits only via reset

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        jalr,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    output logic        misaligned
);

    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;
`endif

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        req_q;
    logic        valid_q;
    logic [31:0] target_raw;
    logic [31:0] next_pc_d;
    logic        retire;

    assign retire = (state_q == S_HOLD) && instr_ready;

    // Next-PC selection; only meaningful on the retire cycle, so X on the
    // control inputs at other times never reaches the registers.
    always_comb begin
        target_raw = pc_q + 32'd4;
        if (jalr)
            target_raw = {ALUResult[31:1], 1'b0};
        else if (Jump || Branch)
            target_raw = pc_q + ImmExt;
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned_q;
    logic target_bad;

    assign next_pc_d  = target_raw;
    assign target_bad = target_raw[1];
    assign misaligned = misaligned_q;

    // Fetch FSM with registered outputs, including the misalign trap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            instr_q      <= NOP;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        state_q <= S_HOLD;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (retire) begin
                        pc_q    <= next_pc_d;
                        valid_q <= 1'b0;
                        if (target_bad) begin
                            state_q      <= S_HALT;
                            misaligned_q <= 1'b1;
                        end else begin
                            state_q <= S_FETCH;
                            req_q   <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end
`else
    // Without the trap, low target bits are simply dropped.
    assign next_pc_d  = target_raw & 32'hFFFF_FFFC;
    assign misaligned = 1'b0;

    // Fetch FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        state_q <= S_HOLD;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (retire) begin
                        pc_q    <= next_pc_d;
                        valid_q <= 1'b0;
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end
`endif

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign Instr       = instr_q;
    assign PC          = pc_q;
    assign PCPlus4     = pc_q + 32'd4;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with RESET_PC = 32'h100.
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        Branch;
    logic        Jump;
    logic        jalr;
    logic [31:0] ImmExt;
    logic [31:0] ALUResult;
    logic        misaligned;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .Branch(Branch), .Jump(Jump), .jalr(jalr),
        .ImmExt(ImmExt), .ALUResult(ALUResult),
        .misaligned(misaligned)
    );

    task automatic clear_inputs();
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        Branch      = 1'b0;
        Jump        = 1'b0;
        jalr        = 1'b0;
        ImmExt      = 32'h0;
        ALUResult   = 32'h0;
    endtask

    // Reset, then release; returns at the negedge where the first request is up.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // From a FETCH negedge: ack this cycle, return at the HOLD negedge.
    task automatic ack_fetch(input logic [31:0] word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hxxxx_xxxx;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        #1;
        total++; if (PC !== 32'h100) $display("FAIL reset_pc got %h exp %h", PC, 32'h100); else passed++;
        total++; if (PCPlus4 !== 32'h104) $display("FAIL reset_pcplus4 got %h exp %h", PCPlus4, 32'h104); else passed++;
        total++; if (Instr !== 32'h13) $display("FAIL reset_instr got %h exp %h", Instr, 32'h13); else passed++;
        total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", instr_valid); else passed++;
        total++; if (imem_req !== 1'b0) $display("FAIL reset_req got %b exp 0", imem_req); else passed++;
        total++; if (misaligned !== 1'b0) $display("FAIL reset_misaligned got %b exp 0", misaligned); else passed++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0) $display("FAIL req_before_first_edge got %b exp 0", imem_req); else passed++;
    endtask

    task automatic test_first_fetch();
        @(negedge clk);
        total++; if (imem_req !== 1'b1) $display("FAIL first_req got %b exp 1", imem_req); else passed++;
        total++; if (imem_addr !== 32'h100) $display("FAIL first_addr got %h exp %h", imem_addr, 32'h100); else passed++;
        total++; if (instr_valid !== 1'b0) $display("FAIL first_valid_low got %b exp 0", instr_valid); else passed++;
        ack_fetch(32'h0050_0093);
        total++; if (instr_valid !== 1'b1) $display("FAIL first_valid got %b exp 1", instr_valid); else passed++;
        total++; if (Instr !== 32'h0050_0093) $display("FAIL first_instr got %h exp %h", Instr, 32'h0050_0093); else passed++;
        total++; if (imem_req !== 1'b0) $display("FAIL hold_req got %b exp 0", imem_req); else passed++;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        total++; if (imem_addr !== 32'h104) $display("FAIL seq_addr got %h exp %h", imem_addr, 32'h104); else passed++;
        total++; if (imem_req !== 1'b1) $display("FAIL seq_req got %b exp 1", imem_req); else passed++;
    endtask

    // Three wait cycles, with a stray instr_ready that must do nothing.
    task automatic test_wait_states();
        for (int i = 0; i < 3; i++) begin
            instr_ready = 1'b1;
            total++; if (imem_addr !== 32'h104) $display("FAIL wait_addr[%0d] got %h exp %h", i, imem_addr, 32'h104); else passed++;
            total++; if (instr_valid !== 1'b0) $display("FAIL wait_valid[%0d] got %b exp 0", i, instr_valid); else passed++;
            total++; if (imem_req !== 1'b1) $display("FAIL wait_req[%0d] got %b exp 1", i, imem_req); else passed++;
            @(negedge clk);
        end
        instr_ready = 1'b0;
        total++; if (imem_addr !== 32'h104) $display("FAIL wait_addr[3] got %h exp %h", imem_addr, 32'h104); else passed++;
        ack_fetch(32'hFE00_0CE3);
        total++; if (instr_valid !== 1'b1) $display("FAIL wait_done_valid got %b exp 1", instr_valid); else passed++;
        total++; if (Instr !== 32'hFE00_0CE3) $display("FAIL wait_done_instr got %h exp %h", Instr, 32'hFE00_0CE3); else passed++;
    endtask

    task automatic test_branch();
        Branch = 1'b1;
        ImmExt = 32'hFFFF_FFF8;
        @(negedge clk);
        total++; if (PC !== 32'h104) $display("FAIL branch_noretire_pc got %h exp %h", PC, 32'h104); else passed++;
        total++; if (instr_valid !== 1'b1) $display("FAIL branch_noretire_valid got %b exp 1", instr_valid); else passed++;
        instr_ready = 1'b1;
        @(negedge clk);
        clear_inputs();
        total++; if (imem_addr !== 32'h0FC) $display("FAIL branch_target got %h exp %h", imem_addr, 32'h0FC); else passed++;
        ack_fetch(32'h0000_0013);
        total++; if (PCPlus4 !== 32'h100) $display("FAIL branch_pcplus4 got %h exp %h", PCPlus4, 32'h100); else passed++;
    endtask

    // jalr has priority over Jump; ALUResult bit0 cleared, bit1 left set.
    task automatic test_jalr_priority();
        jalr        = 1'b1;
        Jump        = 1'b1;
        ImmExt      = 32'h40;
        ALUResult   = 32'h203;
        instr_ready = 1'b1;
        @(negedge clk);
        clear_inputs();
`ifdef FETCH_MISALIGN_TRAP_EN
        total++; if (PC !== 32'h202) $display("FAIL jalr_trap_pc got %h exp %h", PC, 32'h202); else passed++;
        total++; if (misaligned !== 1'b1) $display("FAIL jalr_trap_flag got %b exp 1", misaligned); else passed++;
        total++; if (imem_req !== 1'b0) $display("FAIL jalr_trap_req got %b exp 0", imem_req); else passed++;
        imem_ack    = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clear_inputs();
        total++; if (misaligned !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0)
            $display("FAIL halt_sticky got mis=%b req=%b valid=%b exp 1/0/0", misaligned, imem_req, instr_valid);
        else passed++;
        do_reset();
        total++; if (misaligned !== 1'b0) $display("FAIL halt_reset_flag got %b exp 0", misaligned); else passed++;
        // Re-create an aligned PC of 32'h200 so the following tests start alike.
        ack_fetch(32'h0000_0013);
        jalr        = 1'b1;
        ALUResult   = 32'h200;
        instr_ready = 1'b1;
        @(negedge clk);
        clear_inputs();
`endif
        total++; if (imem_addr !== 32'h200) $display("FAIL jalr_target got %h exp %h", imem_addr, 32'h200); else passed++;
        total++; if (misaligned !== 1'b0) $display("FAIL jalr_no_flag got %b exp 0", misaligned); else passed++;
    endtask

    // Jump from 32'h200, then jalr to the top word and wrap sequentially.
    task automatic test_jump_and_wrap();
        ack_fetch(32'h0200_006F);
        Jump        = 1'b1;
        ImmExt      = 32'h20;
        instr_ready = 1'b1;
        @(negedge clk);
        clear_inputs();
        total++; if (imem_addr !== 32'h220) $display("FAIL jump_target got %h exp %h", imem_addr, 32'h220); else passed++;
        ack_fetch(32'h0000_0067);
        jalr        = 1'b1;
        ALUResult   = 32'hFFFF_FFFD;
        instr_ready = 1'b1;
        @(negedge clk);
        clear_inputs();
        total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL top_target got %h exp %h", imem_addr, 32'hFFFF_FFFC); else passed++;
        ack_fetch(32'h0000_0013);
        total++; if (PCPlus4 !== 32'h0) $display("FAIL wrap_pcplus4 got %h exp %h", PCPlus4, 32'h0); else passed++;
        instr_ready = 1'b1;
        @(negedge clk);
        clear_inputs();
        total++; if (imem_addr !== 32'h0) $display("FAIL wrap_addr got %h exp %h", imem_addr, 32'h0); else passed++;
    endtask

    // Back-to-back zero-wait fetches: one instruction every two cycles.
    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            ack_fetch(32'h0000_0113 + i);
            total++; if (instr_valid !== 1'b1 || PC !== 32'(4 * i))
                $display("FAIL b2b_hold[%0d] got valid=%b pc=%h exp 1/%h", i, instr_valid, PC, 32'(4 * i));
            else passed++;
            instr_ready = 1'b1;
            @(negedge clk);
            instr_ready = 1'b0;
        end
        total++; if (imem_addr !== 32'hC) $display("FAIL b2b_addr got %h exp %h", imem_addr, 32'hC); else passed++;
    endtask

    task automatic test_reset_mid_fetch();
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        #1;
        reset = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) $display("FAIL midreset_req got %b exp 0", imem_req); else passed++;
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
        #1;
        total++; if (PC !== 32'h100) $display("FAIL midreset_pc got %h exp %h", PC, 32'h100); else passed++;
        total++; if (Instr !== 32'h13) $display("FAIL midreset_instr got %h exp %h", Instr, 32'h13); else passed++;
        @(negedge clk);
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100)
            $display("FAIL midreset_refetch got req=%b addr=%h exp 1/%h", imem_req, imem_addr, 32'h100);
        else passed++;
    endtask

    // Reset while an instruction is held: it must never retire.
    task automatic test_reset_in_hold();
        ack_fetch(32'h0000_0513);
        instr_ready = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        instr_ready = 1'b0;
        total++; if (PC !== 32'h100 || instr_valid !== 1'b0)
            $display("FAIL holdreset got pc=%h valid=%b exp %h/0", PC, instr_valid, 32'h100);
        else passed++;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_first_fetch();
        test_wait_states();
        test_branch();
        test_jalr_priority();
        test_jump_and_wrap();
        test_back_to_back();
        test_reset_mid_fetch();
        test_reset_in_hold();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
